// File: rtl/vec_alu_seq.sv
// Multi-cycle vector ALU sequencer: decodes vfunct and steps an element index. For dot products
// it accumulates the ALU results. Optional ALU stall input is enabled by VALU_SEQ_STALL_EN.
module vec_alu_seq #(
  parameter int unsigned VLEN = 4,
  parameter int unsigned EW   = 32,
  parameter int unsigned IW   = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          ready_o,
  input  logic [9:0]    vfunct_i,
  output logic [IW-1:0] elem_idx_o,
  output logic [2:0]    valu_ctrl_o,
  input  logic [EW-1:0] alu_res_i,
`ifdef VALU_SEQ_STALL_EN
  input  logic          alu_stall_i,
`endif
  output logic          wr_en_o,
  output logic [IW-1:0] wr_idx_o,
  output logic [EW-1:0] wr_data_o,
  output logic          done_o,
  output logic          err_o
);

  typedef enum logic [1:0] {StIdle, StExec, StAccw, StDone} state_e;

  localparam logic [IW-1:0] LastIdx = IW'(VLEN - 1);
  localparam logic [2:0]    CtrlDot = 3'b001;

  state_e        r_state, w_state_d;
  logic [IW-1:0] r_idx;
  logic [2:0]    r_ctrl;
  logic          r_err;
  logic [EW-1:0] r_acc;

  logic          w_dec_legal;
  logic [2:0]    w_dec_ctrl;
  logic          w_accept;
  logic          w_is_dot;
  logic          w_stall;
  logic          w_last;

`ifdef VALU_SEQ_STALL_EN
  assign w_stall = alu_stall_i;
`else
  assign w_stall = 1'b0;
`endif

  // vfunct = {funct6, vm, funct3}
  always_comb begin
    w_dec_legal = 1'b1;
    w_dec_ctrl  = 3'b000;
    case (vfunct_i)
      10'b000000_1_001: w_dec_ctrl = 3'b010;
      10'b010000_1_000: w_dec_ctrl = 3'b110;
      10'b000000_1_111: w_dec_ctrl = 3'b000;
      10'b000000_1_110: w_dec_ctrl = CtrlDot;
      default:          w_dec_legal = 1'b0;
    endcase
  end

  assign w_accept = (r_state == StIdle) && start_i;
  assign w_is_dot = (r_ctrl == CtrlDot);
  assign w_last   = (r_idx == LastIdx);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (start_i) begin
          w_state_d = w_dec_legal ? StExec : StDone;
        end
      end
      StExec: begin
        if (!w_stall && w_last) begin
          w_state_d = w_is_dot ? StAccw : StDone;
        end
      end
      StAccw:  w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Datapath registers: op latch, element index, dot accumulator
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx  <= '0;
      r_ctrl <= 3'b000;
      r_err  <= 1'b0;
      r_acc  <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
      r_acc <= '0;
      r_err <= !w_dec_legal;
      if (w_dec_legal) begin
        r_ctrl <= w_dec_ctrl;
      end
    end else if (r_state == StExec && !w_stall) begin
      r_idx <= w_last ? '0 : r_idx + IW'(1);
      if (w_is_dot) begin
        r_acc <= r_acc + alu_res_i;
      end
    end
  end

  // Output logic
  always_comb begin
    ready_o   = 1'b0;
    wr_en_o   = 1'b0;
    wr_idx_o  = '0;
    wr_data_o = '0;
    done_o    = 1'b0;
    err_o     = 1'b0;
    case (r_state)
      StIdle: ready_o = 1'b1;
      StExec: begin
        if (!w_is_dot && !w_stall) begin
          wr_en_o   = 1'b1;
          wr_idx_o  = r_idx;
          wr_data_o = alu_res_i;
        end
      end
      StAccw: begin
        wr_en_o   = 1'b1;
        wr_data_o = r_acc;
      end
      StDone: begin
        done_o = 1'b1;
        err_o  = r_err;
      end
      default: ;
    endcase
  end

  assign elem_idx_o  = r_idx;
  assign valu_ctrl_o = r_ctrl;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Scoreboard bench for vec_alu_seq: directed plan cases plus randomized instructions
// checked against a behavioural model of the instruction set.
module tb_vec_alu_seq;
  localparam int VLEN = 4;
  localparam int EW   = 32;
  localparam int IW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ready;
  logic [9:0]    vfunct;
  logic [IW-1:0] elem_idx;
  logic [2:0]    valu_ctrl;
  logic [EW-1:0] alu_res;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [EW-1:0] wr_data;
  logic          done;
  logic          err;
`ifdef VALU_SEQ_STALL_EN
  logic          stall;
`endif

  logic [EW-1:0] res_tab [VLEN];

  vec_alu_seq #(.VLEN(VLEN), .EW(EW), .IW(IW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .ready_o    (ready),
    .vfunct_i   (vfunct),
    .elem_idx_o (elem_idx),
    .valu_ctrl_o(valu_ctrl),
    .alu_res_i  (alu_res),
`ifdef VALU_SEQ_STALL_EN
    .alu_stall_i(stall),
`endif
    .wr_en_o    (wr_en),
    .wr_idx_o   (wr_idx),
    .wr_data_o  (wr_data),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  // Element ALU stand-in: result depends only on the presented index
  always_comb alu_res = res_tab[elem_idx];

  typedef struct {
    logic [IW-1:0] idx;
    logic [EW-1:0] data;
    logic [2:0]    ctrl;
  } wr_t;
  typedef struct {
    int   cyc;
    logic err;
  } dn_t;

  wr_t wr_q[$];
  dn_t dn_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic fail(input string name, input logic [63:0] got);
    n_chk++;
    $display("FAIL %s: got %0h required none (t=%0t)", name, got, $time);
  endtask

  // Reference model: what the instruction set says should be written, and when done appears
  task automatic model_push(input logic [9:0] vf, input int acc_cyc, input int extra);
    logic [5:0] f6;
    logic       vm;
    logic [2:0] f3;
    logic       legal;
    logic       is_dot;
    logic [2:0] ctrl;
    longint unsigned sum;
    wr_t w;
    dn_t d;
    f6 = vf[9:4];
    vm = vf[3];
    f3 = vf[2:0];
    legal  = 1'b1;
    is_dot = 1'b0;
    ctrl   = 3'b000;
    if (vm && f6 == 6'd0 && f3 == 3'd1)       ctrl = 3'b010;
    else if (vm && f6 == 6'h10 && f3 == 3'd0) ctrl = 3'b110;
    else if (vm && f6 == 6'd0 && f3 == 3'd7)  ctrl = 3'b000;
    else if (vm && f6 == 6'd0 && f3 == 3'd6) begin
      ctrl   = 3'b001;
      is_dot = 1'b1;
    end else legal = 1'b0;

    if (!legal) begin
      d.cyc = acc_cyc + 1;
      d.err = 1'b1;
    end else if (is_dot) begin
      sum = 0;
      for (int i = 0; i < VLEN; i++) sum = sum + res_tab[i];
      sum = sum % (longint'(1) << EW);
      w.idx  = '0;
      w.data = sum[EW-1:0];
      w.ctrl = ctrl;
      wr_q.push_back(w);
      d.cyc = acc_cyc + VLEN + 2 + extra;
      d.err = 1'b0;
    end else begin
      for (int i = 0; i < VLEN; i++) begin
        w.idx  = IW'(i);
        w.data = res_tab[i];
        w.ctrl = ctrl;
        wr_q.push_back(w);
      end
      d.cyc = acc_cyc + VLEN + 1 + extra;
      d.err = 1'b0;
    end
    dn_q.push_back(d);
  endtask

  // Monitor: compares every DUT write and done pulse against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done) chk("ready_after_done", 64'(ready), 64'd1);
      prev_done = done;
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          fail("unexpected_write", {wr_idx, wr_data});
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_idx", 64'(wr_idx), 64'(e.idx));
          chk("wr_data", 64'(wr_data), 64'(e.data));
          chk("valu_ctrl", 64'(valu_ctrl), 64'(e.ctrl));
        end
      end
      if (done) begin
        if (dn_q.size() == 0) begin
          fail("unexpected_done", 64'(cyc));
        end else begin
          dn_t e;
          e = dn_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("err", 64'(err), 64'(e.err));
        end
      end
    end
  end

  task automatic chk_reset();
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_elem_idx", 64'(elem_idx), 64'd0);
    chk("rst_valu_ctrl", 64'(valu_ctrl), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_idx", 64'(wr_idx), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
  endtask

  // Issue one instruction; mode 1 keeps start high while busy, mode 2 stalls index 1 twice
  task automatic issue(input logic [9:0] vf, input logic [EW-1:0] v0, input logic [EW-1:0] v1,
                       input logic [EW-1:0] v2, input logic [EW-1:0] v3, input int mode);
    int n;
    int extra;
    n = 0;
    extra = 0;
`ifdef VALU_SEQ_STALL_EN
    if (mode == 2) extra = 2;
`endif
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) fail("ready_timeout", 64'(ready));
    res_tab[0] = v0;
    res_tab[1] = v1;
    res_tab[2] = v2;
    res_tab[3] = v3;
    vfunct = vf;
    start  = 1'b1;
    model_push(vf, cyc, extra);
    @(posedge clk);
    #1;
    if (mode == 1) begin
      repeat (5) @(posedge clk);
      #1;
    end
    start = 1'b0;
`ifdef VALU_SEQ_STALL_EN
    if (mode == 2) begin
      @(posedge clk);
      #1 stall = 1'b1;
      repeat (2) @(posedge clk);
      #1 stall = 1'b0;
    end
`endif
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wr_q.size() != 0 || dn_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk("dn_q_drained", 64'(dn_q.size()), 64'd0);
  endtask

  initial begin
    logic [9:0] ops [4];
    logic [9:0] vf;
    ops[0] = 10'b0000001001;
    ops[1] = 10'b0100001000;
    ops[2] = 10'b0000001111;
    ops[3] = 10'b0000001110;
    start  = 1'b0;
    vfunct = '0;
`ifdef VALU_SEQ_STALL_EN
    stall  = 1'b0;
`endif
    for (int i = 0; i < VLEN; i++) res_tab[i] = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;

    issue(10'b0000001001, 32'd10, 32'd11, 32'd12, 32'd13, 0);     // add
    issue(10'b0100001000, $urandom, $urandom, $urandom, $urandom, 0); // sub
    issue(10'b0000001110, 32'd3, 32'd4, 32'd5, 32'd6, 0);         // dot -> 18
    issue(10'b0000001110, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 0); // dot wraps -> 1
    issue(10'b0000000001, 32'd1, 32'd2, 32'd3, 32'd4, 0);         // illegal (vm=0)
    issue(10'b0000001001, 32'd7, 32'd8, 32'd9, 32'd10, 1);        // start held while busy
    drain();

    // Reset while a dot product sits at index 2
    issue(10'b0000001110, 32'd5, 32'd6, 32'd7, 32'd8, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("idx_before_reset", 64'(elem_idx), 64'd2);
    rst = 1'b1;
    #1;
    chk_reset();
    wr_q.delete();
    dn_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(10'b0000001001, 32'd21, 32'd22, 32'd23, 32'd24, 0);
`ifdef VALU_SEQ_STALL_EN
    issue(10'b0000001001, 32'd31, 32'd32, 32'd33, 32'd34, 2);
`endif
    drain();

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 4) == 0) vf = 10'($urandom);
      else vf = ops[$urandom_range(0, 3)];
      issue(vf, $urandom, $urandom, $urandom, $urandom, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
